// File: rtl/dcache_port_arbiter_pkg.sv
// Shared types for the data-cache port arbiter: cache commands, FSM states, request payload.
package dcache_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_LOAD  = 3'd1,
    CMD_STORE = 3'd2,
    CMD_FLUSH = 3'd3,
    CMD_INVAL = 3'd4
  } cache_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  typedef struct packed {
    cache_cmd_t        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } arb_req_t;

  // Width of a requester index; at least one bit even for a single requester.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_if.sv
// Requester-side and cache-side signals of the data-cache port arbiter.
interface dcache_port_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  import dcache_port_arbiter_pkg::*;

  localparam int unsigned ID_W = id_width(NREQ);

  logic [NREQ-1:0]             req_valid;
  cache_cmd_t [NREQ-1:0]       req_cmd;
  logic [NREQ-1:0][ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][DATA_W-1:0] req_data;
  logic [NREQ-1:0]             kill;
  logic [NREQ-1:0]             resp_valid;
  logic [DATA_W-1:0]           resp_data;
  cache_cmd_t                  ca_req_cmd;
  logic [ADDR_W-1:0]           ca_req_addr;
  logic [DATA_W-1:0]           ca_req_data;
  logic                        ca_respcyc;
  logic [DATA_W-1:0]           ca_resp_data;
  logic [ID_W-1:0]             grant_id;
  logic                        busy;
  logic                        timeout_err;

  modport slave (
    input  req_valid, req_cmd, req_addr, req_data, kill, ca_respcyc, ca_resp_data,
    output resp_valid, resp_data, ca_req_cmd, ca_req_addr, ca_req_data,
           grant_id, busy, timeout_err
  );

  modport master (
    output req_valid, req_cmd, req_addr, req_data, kill, ca_respcyc, ca_resp_data,
    input  resp_valid, resp_data, ca_req_cmd, ca_req_addr, ca_req_data,
           grant_id, busy, timeout_err
  );

endinterface

// File: rtl/dcache_port_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr, wrapping.
module rr_picker
  import dcache_port_arbiter_pkg::*;
#(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] eligible_i,
  input  logic [ID_W-1:0] rr_ptr_i,
  output logic            winner_valid_o,
  output logic [ID_W-1:0] winner_id_o
);

  int unsigned idx_c;

  // Scan from the pointer, keep the first hit.
  always_comb begin
    winner_valid_o = 1'b0;
    winner_id_o    = '0;
    idx_c          = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_c = (32'(rr_ptr_i) + k) % NREQ;
      if (!winner_valid_o && eligible_i[idx_c]) begin
        winner_valid_o = 1'b1;
        winner_id_o    = ID_W'(idx_c);
      end
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single data-cache request port among NREQ requesters with round-robin
// arbitration, one outstanding transaction, per-requester kill and a sticky watchdog.
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  dcache_port_arbiter_if.slave bus
);

  localparam int unsigned ID_W = id_width(NREQ);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] grant_q, grant_d;
  arb_req_t        ca_req_q, ca_req_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;

  logic [NREQ-1:0] eligible_c;
  logic            win_valid_c;
  logic [ID_W-1:0] win_id_c;
  logic            kill_grant_c;

  assign eligible_c   = bus.req_valid & ~bus.kill;
  assign kill_grant_c = bus.kill[grant_q];

  rr_picker #(.NREQ(NREQ)) u_picker (
    .eligible_i     (eligible_c),
    .rr_ptr_i       (rr_ptr_q),
    .winner_valid_o (win_valid_c),
    .winner_id_o    (win_id_c)
  );

  // Next-state: arbitration in IDLE, completion/kill handling in BUSY/DRAIN, watchdog.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    ca_req_d  = ca_req_q;
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        wd_cnt_d = '0;
        if (win_valid_c) begin
          ca_req_d.cmd  = bus.req_cmd[win_id_c];
          ca_req_d.addr = bus.req_addr[win_id_c];
          ca_req_d.data = bus.req_data[win_id_c];
          grant_d       = win_id_c;
          rr_ptr_d      = ID_W'((32'(win_id_c) + 32'd1) % NREQ);
          state_d       = ST_BUSY;
        end
      end
      ST_BUSY, ST_DRAIN: begin
        if (bus.ca_respcyc) begin
          state_d      = ST_IDLE;
          ca_req_d.cmd = CMD_NONE;
          wd_cnt_d     = '0;
        end else begin
          // The command stays on the cache port; only the response gets dropped.
          if (state_q == ST_BUSY && kill_grant_c) state_d = ST_DRAIN;
          if (wd_cnt_q != CNT_W'(TIMEOUT_CYC)) wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (wd_cnt_d == CNT_W'(TIMEOUT_CYC)) timeout_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      ca_req_q  <= '{cmd: CMD_NONE, addr: '0, data: '0};
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      ca_req_q  <= ca_req_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Response demux: only a live (not killed) BUSY transaction reports completion.
  always_comb begin
    bus.resp_valid = '0;
    if (state_q == ST_BUSY && bus.ca_respcyc && !kill_grant_c) bus.resp_valid[grant_q] = 1'b1;
  end

  assign bus.resp_data   = bus.ca_resp_data;
  assign bus.ca_req_cmd  = ca_req_q.cmd;
  assign bus.ca_req_addr = ca_req_q.addr;
  assign bus.ca_req_data = ca_req_q.data;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.timeout_err = timeout_q;

  // The cache must not signal completion while nothing is outstanding.
  a_no_idle_resp: assert property (@(posedge clk) disable iff (!reset_n)
                                   !(state_q == ST_IDLE && bus.ca_respcyc));

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed scenarios plus a randomized phase checked against a transaction-level model.
module tb_dcache_port_arbiter;
  import dcache_port_arbiter_pkg::*;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  dcache_port_arbiter_if #(.NREQ(NREQ)) bus ();

  dcache_port_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TIMEOUT), .CNT_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid    = '0;
    bus.req_cmd      = '{default: CMD_NONE};
    bus.req_addr     = '0;
    bus.req_data     = '0;
    bus.kill         = '0;
    bus.ca_respcyc   = 1'b0;
    bus.ca_resp_data = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic set_req(input int i, input cache_cmd_t c, input logic [63:0] a, input logic [63:0] d);
    bus.req_cmd[i]  = c;
    bus.req_addr[i] = a;
    bus.req_data[i] = d;
    bus.req_valid[i] = 1'b1;
  endtask

  // Transaction-level reference state for the random phase.
  logic [NREQ-1:0] pend;
  cache_cmd_t      p_cmd  [NREQ];
  logic [63:0]     p_addr [NREQ];
  logic [63:0]     p_data [NREQ];
  bit              m_busy, m_killed, found;
  int unsigned     m_owner, m_ptr, lat_left, cand;
  cache_cmd_t      m_cmd;
  logic [63:0]     m_addr, m_data;
  logic [NREQ-1:0] exp_rv, elig;

  int order [3] = '{0, 1, 0};

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    #1;
    chk("rst_cmd",  64'(bus.ca_req_cmd), 64'(CMD_NONE));
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_addr", bus.ca_req_addr, 64'd0);
    chk("rst_data", bus.ca_req_data, 64'd0);
    chk("rst_gnt",  64'(bus.grant_id), 64'd0);
    chk("rst_to",   64'(bus.timeout_err), 64'd0);
    chk("rst_rv",   64'(bus.resp_valid), 64'd0);
    tick();
    reset_n = 1'b1;

    // 1: single read with a 5-cycle cache latency
    set_req(0, CMD_LOAD, 64'h1000, 64'h0);
    tick();
    chk("t1_cmd",  64'(bus.ca_req_cmd), 64'(CMD_LOAD));
    chk("t1_addr", bus.ca_req_addr, 64'h1000);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    chk("t1_gnt",  64'(bus.grant_id), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_hold", 64'(bus.ca_req_cmd), 64'(CMD_LOAD));
      chk("t1_norv", 64'(bus.resp_valid), 64'd0);
    end
    tick();
    bus.ca_respcyc   = 1'b1;
    bus.ca_resp_data = 64'hDEAD_BEEF_0BAD_F00D;
    #1;
    chk("t1_rv",   64'(bus.resp_valid), 64'b01);
    chk("t1_rdat", bus.resp_data, 64'hDEAD_BEEF_0BAD_F00D);
    tick();
    bus.ca_respcyc = 1'b0;
    bus.req_valid  = '0;
    #1;
    chk("t1_idle", 64'(bus.busy), 64'd0);
    chk("t1_none", 64'(bus.ca_req_cmd), 64'(CMD_NONE));
    chk("t1_rv0",  64'(bus.resp_valid), 64'd0);

    // 2: contention, grant order 0,1,0 with exactly one idle cycle between
    do_reset();
    set_req(0, CMD_LOAD,  64'h2000, 64'h0);
    set_req(1, CMD_STORE, 64'h3000, 64'h55);
    for (int t = 0; t < 3; t++) begin
      tick();
      chk("t2_busy", 64'(bus.busy), 64'd1);
      chk("t2_gnt",  64'(bus.grant_id), 64'(order[t]));
      chk("t2_addr", bus.ca_req_addr, (order[t] == 0) ? 64'h2000 : 64'h3000);
      tick();
      tick();
      bus.ca_respcyc = 1'b1;
      bus.ca_resp_data = 64'(t + 100);
      #1;
      chk("t2_rv", 64'(bus.resp_valid), 64'(1 << order[t]));
      tick();
      bus.ca_respcyc = 1'b0;
      if (t == 2) bus.req_valid = '0;
      #1;
      chk("t2_turn", 64'(bus.busy), 64'd0);
      chk("t2_none", 64'(bus.ca_req_cmd), 64'(CMD_NONE));
    end
    tick();
    chk("t2_quiet", 64'(bus.busy), 64'd0);

    // 3: kill the in-flight transaction of requester 1
    do_reset();
    set_req(1, CMD_STORE, 64'h4000, 64'hABCD);
    tick();
    chk("t3_gnt", 64'(bus.grant_id), 64'd1);
    tick();
    tick();
    bus.kill[1] = 1'b1;
    bus.req_valid[1] = 1'b0;
    #1;
    chk("t3_krv", 64'(bus.resp_valid), 64'd0);
    tick();
    bus.kill = '0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_busy", 64'(bus.busy), 64'd1);
      chk("t3_cmd",  64'(bus.ca_req_cmd), 64'(CMD_STORE));
      chk("t3_addr", bus.ca_req_addr, 64'h4000);
      chk("t3_data", bus.ca_req_data, 64'hABCD);
      if (k < 2) tick();
    end
    bus.ca_respcyc = 1'b1;
    #1;
    chk("t3_drv", 64'(bus.resp_valid), 64'd0);
    tick();
    bus.ca_respcyc = 1'b0;
    #1;
    chk("t3_idle", 64'(bus.busy), 64'd0);
    chk("t3_none", 64'(bus.ca_req_cmd), 64'(CMD_NONE));

    // 4: kill coincident with the response
    do_reset();
    set_req(0, CMD_LOAD, 64'h5000, 64'h0);
    tick();
    tick();
    bus.kill[0] = 1'b1;
    bus.req_valid[0] = 1'b0;
    bus.ca_respcyc = 1'b1;
    #1;
    chk("t4_rv", 64'(bus.resp_valid), 64'd0);
    tick();
    clear_inputs();
    #1;
    chk("t4_idle", 64'(bus.busy), 64'd0);

    // random phase against the transaction-level model
    do_reset();
    pend = '0; m_busy = 0; m_killed = 0; m_owner = 0; m_ptr = 0; lat_left = 0;
    m_cmd = CMD_NONE; m_addr = '0; m_data = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      chk("rnd_busy", 64'(bus.busy), 64'(m_busy));
      chk("rnd_cmd",  64'(bus.ca_req_cmd), m_busy ? 64'(m_cmd) : 64'(CMD_NONE));
      chk("rnd_to",   64'(bus.timeout_err), 64'd0);
      if (m_busy) begin
        chk("rnd_gnt",  64'(bus.grant_id), 64'(m_owner));
        chk("rnd_addr", bus.ca_req_addr, m_addr);
        chk("rnd_data", bus.ca_req_data, m_data);
      end
      bus.kill = '0;
      bus.ca_respcyc = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          p_cmd[i]  = cache_cmd_t'(3'($urandom_range(1, 4)));
          p_addr[i] = {$urandom, $urandom};
          p_data[i] = {$urandom, $urandom};
          bus.req_cmd[i]  = p_cmd[i];
          bus.req_addr[i] = p_addr[i];
          bus.req_data[i] = p_data[i];
        end
      end
      bus.req_valid = pend;
      for (int i = 0; i < NREQ; i++)
        if (pend[i] && $urandom_range(0, 11) == 0) bus.kill[i] = 1'b1;
      if (m_busy) begin
        lat_left--;
        if (lat_left == 0) begin
          bus.ca_respcyc   = 1'b1;
          bus.ca_resp_data = {$urandom, $urandom};
        end
      end
      #1;
      exp_rv = '0;
      if (m_busy && bus.ca_respcyc && !m_killed && !bus.kill[m_owner]) exp_rv[m_owner] = 1'b1;
      chk("rnd_rv", 64'(bus.resp_valid), 64'(exp_rv));
      if (exp_rv != '0) chk("rnd_rdat", bus.resp_data, bus.ca_resp_data);
      if (m_busy) begin
        if (bus.ca_respcyc) begin
          m_busy = 0;
          if (exp_rv != '0) pend[m_owner] = 1'b0;
        end else if (bus.kill[m_owner]) begin
          m_killed = 1;
        end
      end else begin
        elig  = pend & ~bus.kill;
        found = 0;
        for (int k = 0; k < NREQ; k++) begin
          cand = (m_ptr + k) % NREQ;
          if (!found && elig[cand]) begin
            found    = 1;
            m_busy   = 1;
            m_killed = 0;
            m_owner  = cand;
            m_cmd    = p_cmd[cand];
            m_addr   = p_addr[cand];
            m_data   = p_data[cand];
            m_ptr    = (cand + 1) % NREQ;
            lat_left = $urandom_range(1, 6);
          end
        end
      end
      pend = pend & ~bus.kill;
      tick();
    end
    bus.req_valid = '0;
    bus.kill = '0;
    bus.ca_respcyc = 1'b0;
    if (m_busy) begin
      for (int k = 0; k < 7 && lat_left > 1; k++) begin
        lat_left--;
        tick();
      end
      bus.ca_respcyc = 1'b1;
      tick();
      bus.ca_respcyc = 1'b0;
    end

    // 5: watchdog with a cache that never answers
    do_reset();
    set_req(0, CMD_FLUSH, 64'h6000, 64'h0);
    tick();
    chk("t5_busy", 64'(bus.busy), 64'd1);
    chk("t5_to0",  64'(bus.timeout_err), 64'd0);
    for (int j = 1; j <= int'(TIMEOUT); j++) begin
      tick();
      chk("t5_to", 64'(bus.timeout_err), (j == int'(TIMEOUT)) ? 64'd1 : 64'd0);
    end
    tick();
    chk("t5_sat", 64'(bus.timeout_err), 64'd1);
    bus.ca_respcyc = 1'b1;
    #1;
    chk("t5_rv", 64'(bus.resp_valid), 64'b01);
    tick();
    bus.ca_respcyc = 1'b0;
    bus.req_valid  = '0;
    #1;
    chk("t5_idle",   64'(bus.busy), 64'd0);
    chk("t5_sticky", 64'(bus.timeout_err), 64'd1);
    tick();
    chk("t5_sticky2", 64'(bus.timeout_err), 64'd1);

    // 6: asynchronous reset in the middle of a transaction
    set_req(0, CMD_LOAD, 64'h7000, 64'h0);
    tick();
    chk("t6_gnt", 64'(bus.grant_id), 64'd0);
    bus.req_valid = '0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_cmd",  64'(bus.ca_req_cmd), 64'(CMD_NONE));
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_to",   64'(bus.timeout_err), 64'd0);
    chk("t6_addr", bus.ca_req_addr, 64'd0);
    tick();
    set_req(0, CMD_LOAD,  64'h8000, 64'h0);
    set_req(1, CMD_STORE, 64'h9000, 64'h1);
    reset_n = 1'b1;
    tick();
    chk("t6_first", 64'(bus.grant_id), 64'd0);
    chk("t6_faddr", bus.ca_req_addr, 64'h8000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
